// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer.
// Holds the command mode encoding, the controller state encoding, the
// counter select values and a helper that picks the starting direction.
package count_seq_pkg;

    // Direction modes carried by a command; the fourth encoding is reserved
    // and behaves like MODE_UP.
    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_e;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_RELOAD = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // Datapath select values.
    localparam logic SEL_UP   = 1'b0;
    localparam logic SEL_DOWN = 1'b1;

    // Direction of the first pass of a command: only DOWN starts counting down.
    // PINGPONG and the reserved mode both start upward.
    function automatic logic start_dir(input logic [1:0] mode);
        start_dir = (mode == MODE_DOWN) ? SEL_DOWN : SEL_UP;
    endfunction

    // A command with no steps or no passes does nothing useful and is flagged.
    function automatic logic is_illegal(input logic limit_zero, input logic passes_zero);
        is_illegal = limit_zero | passes_zero;
    endfunction

endpackage

// File: rtl/count_seq_target.sv
// Terminal-value detector for the count sequencer.
// Counting up, the pass ends when the datapath reaches the limit. Counting
// down from 0 the datapath wraps, so the pass ends at the two's-complement
// negative of the limit (limit=3 ends at 13 for WIDTH=4).
module count_seq_target
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] ctr_value,
    output logic             hit
);

    logic [WIDTH-1:0] target;

    // Select the terminal value for the current direction and compare.
    always_comb begin
        target = limit;
        if (dir == SEL_DOWN) begin
            target = -limit;
        end
        hit = (ctr_value == target);
    end

endmodule

// File: rtl/up_down_counter.sv
// Up/down counter datapath driven by the count sequencer.
// Synchronous clear has priority; otherwise it steps by one in the selected
// direction every cycle, wrapping at the width boundary.
module up_down_counter
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             select,
    output logic [WIDTH-1:0] count_value
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    // Clear or step the count every cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_value <= '0;
        end else if (select == SEL_DOWN) begin
            count_value <= count_value - STEP;
        end else begin
            count_value <= count_value + STEP;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Count sequencer: accepts one command at a time (mode, limit, passes) over a
// valid/ready handshake and sequences an external up/down counter through the
// requested number of passes, pulsing pass_done per pass and done at the end.
// Optional feature: define COUNT_SEQ_ABORT_EN to add the abort input, which
// ends a running command early with err set.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [WIDTH-1:0]  cmd_limit,
    input  logic [PASS_W-1:0] cmd_passes,
    output logic              ctr_clear,
    output logic              ctr_select,
    input  logic [WIDTH-1:0]  ctr_value,
`ifdef COUNT_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              pass_done,
    output logic              done,
    output logic              err
);

    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

    state_e            state;
    state_e            state_d;
    logic [1:0]        mode_q;
    logic [1:0]        mode_d;
    logic [WIDTH-1:0]  limit_q;
    logic [WIDTH-1:0]  limit_d;
    logic [PASS_W-1:0] passes_q;
    logic [PASS_W-1:0] passes_d;
    logic [PASS_W-1:0] pass_cnt;
    logic [PASS_W-1:0] pass_cnt_d;
    logic              dir;
    logic              dir_d;
    logic              err_q;
    logic              err_d;
    logic              accept;
    logic              hit;
    logic              abort_req;

`ifdef COUNT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept = cmd_valid && (state == S_IDLE);

    count_seq_target #(
        .WIDTH(WIDTH)
    ) u_target (
        .dir       (dir),
        .limit     (limit_q),
        .ctr_value (ctr_value),
        .hit       (hit)
    );

    // State, latched command and pass bookkeeping registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= S_IDLE;
            mode_q   <= '0;
            limit_q  <= '0;
            passes_q <= '0;
            pass_cnt <= '0;
            dir      <= SEL_UP;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            mode_q   <= mode_d;
            limit_q  <= limit_d;
            passes_q <= passes_d;
            pass_cnt <= pass_cnt_d;
            dir      <= dir_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic and Moore output decode from the registered state.
    always_comb begin
        state_d    = state;
        mode_d     = mode_q;
        limit_d    = limit_q;
        passes_d   = passes_q;
        pass_cnt_d = pass_cnt;
        dir_d      = dir;
        err_d      = err_q;

        cmd_ready  = 1'b0;
        busy       = 1'b1;
        ctr_clear  = 1'b1;
        ctr_select = SEL_UP;
        pass_done  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    mode_d     = cmd_mode;
                    limit_d    = cmd_limit;
                    passes_d   = cmd_passes;
                    dir_d      = start_dir(cmd_mode);
                    pass_cnt_d = '0;
                    if (is_illegal(cmd_limit == '0, cmd_passes == '0)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                ctr_clear  = 1'b0;
                ctr_select = dir;
                if (abort_req) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (hit) begin
                    pass_cnt_d = pass_cnt + PASS_ONE;
                    if ((pass_cnt + PASS_ONE) == passes_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RELOAD;
                    end
                end
            end

            S_RELOAD: begin
                pass_done = 1'b1;
                if (abort_req) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (mode_q == MODE_PINGPONG) begin
                        dir_d = ~dir;
                    end
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                done       = 1'b1;
                err        = err_q;
                pass_done  = ~err_q;
                pass_cnt_d = '0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer driving an up_down_counter.
// A queue-based model expands each accepted command into the per-cycle
// output pattern it must produce; a compare process checks every cycle.
// Directed traces pin the model against hand-computed timelines.
// Define COUNT_SEQ_ABORT_EN to also exercise abort.
module tb_count_sequencer;

    localparam int WIDTH  = 4;
    localparam int PASS_W = 4;

    logic              clk = 1'b0;
    logic              clear_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_mode = 2'd0;
    logic [WIDTH-1:0]  cmd_limit = '0;
    logic [PASS_W-1:0] cmd_passes = '0;
    logic              ctr_clear;
    logic              ctr_select;
    logic [WIDTH-1:0]  ctr_value;
    logic              busy;
    logic              pass_done;
    logic              done;
    logic              err;
    logic              abort = 1'b0;

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;

    count_sequencer #(
        .WIDTH(WIDTH),
        .PASS_W(PASS_W)
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_limit  (cmd_limit),
        .cmd_passes (cmd_passes),
        .ctr_clear  (ctr_clear),
        .ctr_select (ctr_select),
        .ctr_value  (ctr_value),
`ifdef COUNT_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .pass_done  (pass_done),
        .done       (done),
        .err        (err)
    );

    up_down_counter #(
        .WIDTH(WIDTH)
    ) u_ctr (
        .clk         (clk),
        .clear       (ctr_clear),
        .select      (ctr_select),
        .count_value (ctr_value)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       clr;
        logic       sel;
        logic       pdone;
        logic       done;
        logic       err;
        logic       chk_val;
        logic       abortable;
        logic [3:0] val;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    function automatic exp_t idle_rec();
        exp_t r;
        r = '0;
        r.ready = 1'b1;
        r.clr   = 1'b1;
        return r;
    endfunction

    function automatic exp_t run_rec(input logic d, input logic [3:0] v);
        exp_t r;
        r = '0;
        r.busy      = 1'b1;
        r.sel       = d;
        r.chk_val   = 1'b1;
        r.abortable = 1'b1;
        r.val       = v;
        return r;
    endfunction

    function automatic exp_t reload_rec();
        exp_t r;
        r = '0;
        r.busy      = 1'b1;
        r.clr       = 1'b1;
        r.pdone     = 1'b1;
        r.abortable = 1'b1;
        return r;
    endfunction

    function automatic exp_t done_rec(input logic e);
        exp_t r;
        r = '0;
        r.busy  = 1'b1;
        r.clr   = 1'b1;
        r.pdone = ~e;
        r.done  = 1'b1;
        r.err   = e;
        return r;
    endfunction

    // Expand one accepted command into the cycles that follow it.
    task automatic build_command(input logic [1:0] m, input logic [3:0] l, input logic [3:0] p);
        logic d;
        int   np;
        int   nl;
        np = int'(p);
        nl = int'(l);
        if (nl == 0 || np == 0) begin
            q.push_back(done_rec(1'b1));
            return;
        end
        d = (m == 2'd1);
        for (int k = 0; k < np; k++) begin
            for (int s = 0; s <= nl; s++) begin
                q.push_back(run_rec(d, d ? 4'((16 - s) % 16) : 4'(s)));
            end
            if (k == np - 1) begin
                q.push_back(done_rec(1'b0));
            end else begin
                q.push_back(reload_rec());
                if (m == 2'd2) d = ~d;
            end
        end
    endtask

    // Advance the model one cycle, or return it to idle on reset.
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q.delete();
            cur = idle_rec();
        end else if (abort && cur.abortable) begin
            q.delete();
            cur = done_rec(1'b1);
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.ready && cmd_valid) begin
            build_command(cmd_mode, cmd_limit, cmd_passes);
            cur = q.pop_front();
        end else begin
            cur = idle_rec();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (started && clear_n) begin
            checkOutput("outputs{rdy,busy,clr,sel,pdone,done,err}",
                        {25'd0, cmd_ready, busy, ctr_clear, ctr_select, pass_done, done, err},
                        {25'd0, cur.ready, cur.busy, cur.clr, cur.sel, cur.pdone, cur.done, cur.err});
            if (cur.chk_val) begin
                checkOutput("ctr_value", 32'(ctr_value), 32'(cur.val));
            end
        end
    end

    // ---------------- directed trace capture ----------------
    logic tr_ready [0:31];
    logic tr_busy  [0:31];
    logic tr_clr   [0:31];
    logic tr_sel   [0:31];
    logic tr_pdone [0:31];
    logic tr_done  [0:31];
    logic tr_err   [0:31];
    logic [3:0] tr_val [0:31];

    task automatic runTrace(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            tr_ready[i] = cmd_ready;
            tr_busy[i]  = busy;
            tr_clr[i]   = ctr_clear;
            tr_sel[i]   = ctr_select;
            tr_pdone[i] = pass_done;
            tr_done[i]  = done;
            tr_err[i]   = err;
            tr_val[i]   = ctr_value;
        end
    endtask

    task automatic waitIdle();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) break;
        end
        if (i == 2000) begin
            checkOutput("wait_idle_timeout", 32'd1, 32'd0);
        end
    endtask

    // Offer a command; returns just after the accepting edge (cycle 0).
    task automatic applyStimulus(input logic [1:0] m, input logic [3:0] l, input logic [3:0] p, input logic hold);
        waitIdle();
        #1;
        cmd_valid  = 1'b1;
        cmd_mode   = m;
        cmd_limit  = l;
        cmd_passes = p;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt_p;
        int cnt_d;
        int found;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        clear_n = 1'b1;
        started = 1'b1;

        checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_busy",  32'(busy),      32'd0);
        checkOutput("reset_clear", 32'(ctr_clear), 32'd1);
        checkOutput("reset_done",  32'(done),      32'd0);

        $display("[TB] UP limit=3 passes=1");
        applyStimulus(2'd0, 4'd3, 4'd1, 1'b0);
        runTrace(6);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("up3_val", 32'(tr_val[i]), 32'(i - 1));
            checkOutput("up3_clr", 32'(tr_clr[i]), 32'd0);
        end
        checkOutput("up3_done4",  32'(tr_done[4]),  32'd0);
        checkOutput("up3_done5",  32'(tr_done[5]),  32'd1);
        checkOutput("up3_pdone5", 32'(tr_pdone[5]), 32'd1);
        checkOutput("up3_err5",   32'(tr_err[5]),   32'd0);
        checkOutput("up3_ready6", 32'(tr_ready[6]), 32'd1);

        $display("[TB] DOWN limit=3 passes=1");
        applyStimulus(2'd1, 4'd3, 4'd1, 1'b0);
        runTrace(6);
        checkOutput("dn3_sel",  32'(tr_sel[1]), 32'd1);
        checkOutput("dn3_val1", 32'(tr_val[1]), 32'd0);
        checkOutput("dn3_val2", 32'(tr_val[2]), 32'd15);
        checkOutput("dn3_val4", 32'(tr_val[4]), 32'd13);
        checkOutput("dn3_done5", 32'(tr_done[5]), 32'd1);

        $display("[TB] PINGPONG limit=2 passes=3");
        applyStimulus(2'd2, 4'd2, 4'd3, 1'b0);
        runTrace(13);
        checkOutput("pp_sel1", 32'(tr_sel[1]), 32'd0);
        checkOutput("pp_sel5", 32'(tr_sel[5]), 32'd1);
        checkOutput("pp_sel9", 32'(tr_sel[9]), 32'd0);
        checkOutput("pp_clr4", 32'(tr_clr[4]), 32'd1);
        checkOutput("pp_clr8", 32'(tr_clr[8]), 32'd1);
        checkOutput("pp_done12", 32'(tr_done[12]), 32'd1);
        cnt_p = 0;
        cnt_d = 0;
        for (int i = 1; i <= 13; i++) begin
            cnt_p += int'(tr_pdone[i]);
            cnt_d += int'(tr_done[i]);
        end
        checkOutput("pp_pass_done_count", 32'(cnt_p), 32'd3);
        checkOutput("pp_done_count",      32'(cnt_d), 32'd1);

        $display("[TB] illegal commands");
        applyStimulus(2'd0, 4'd0, 4'd2, 1'b0);
        runTrace(2);
        checkOutput("lim0_done",  32'(tr_done[1]),  32'd1);
        checkOutput("lim0_err",   32'(tr_err[1]),   32'd1);
        checkOutput("lim0_pdone", 32'(tr_pdone[1]), 32'd0);
        checkOutput("lim0_clr",   32'(tr_clr[1]),   32'd1);
        checkOutput("lim0_ready2", 32'(tr_ready[2]), 32'd1);
        applyStimulus(2'd1, 4'd5, 4'd0, 1'b0);
        runTrace(1);
        checkOutput("pas0_err", 32'(tr_err[1]), 32'd1);
        checkOutput("pas0_clr", 32'(tr_clr[1]), 32'd1);

        $display("[TB] wrap-around limits");
        applyStimulus(2'd1, 4'd15, 4'd1, 1'b0);
        runTrace(17);
        checkOutput("dn15_val16",  32'(tr_val[16]),  32'd1);
        checkOutput("dn15_done16", 32'(tr_done[16]), 32'd0);
        checkOutput("dn15_done17", 32'(tr_done[17]), 32'd1);
        applyStimulus(2'd3, 4'd15, 4'd1, 1'b0);
        runTrace(17);
        checkOutput("up15_sel",    32'(tr_sel[1]),   32'd0);
        checkOutput("up15_val16",  32'(tr_val[16]),  32'd15);
        checkOutput("up15_done17", 32'(tr_done[17]), 32'd1);

        $display("[TB] cmd_valid held high");
        applyStimulus(2'd0, 4'd1, 4'd1, 1'b1);
        runTrace(6);
        cmd_valid = 1'b0;
        checkOutput("hold_ready1", 32'(tr_ready[1]), 32'd0);
        checkOutput("hold_ready3", 32'(tr_ready[3]), 32'd0);
        checkOutput("hold_done3",  32'(tr_done[3]),  32'd1);
        checkOutput("hold_ready4", 32'(tr_ready[4]), 32'd1);
        checkOutput("hold_busy5",  32'(tr_busy[5]),  32'd1);
        cnt_d = 0;
        for (int i = 1; i <= 6; i++) cnt_d += int'(tr_done[i]);
        checkOutput("hold_done_count", 32'(cnt_d), 32'd1);

        $display("[TB] reset mid-RUN");
        applyStimulus(2'd0, 4'd5, 4'd1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #3;
        clear_n = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy",  32'(busy),      32'd0);
        checkOutput("rst_clr",   32'(ctr_clear), 32'd1);
        checkOutput("rst_done",  32'(done),      32'd0);
        @(negedge clk);
        #2;
        clear_n = 1'b1;
        runTrace(8);
        cnt_d = 0;
        for (int i = 1; i <= 8; i++) cnt_d += int'(tr_done[i]);
        checkOutput("rst_no_done", 32'(cnt_d), 32'd0);

`ifdef COUNT_SEQ_ABORT_EN
        $display("[TB] abort");
        applyStimulus(2'd0, 4'd5, 4'd1, 1'b0);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ctr_value == 4'd2 && !ctr_clear) begin found = 1; break; end
        end
        checkOutput("abort_reach2", 32'(found), 32'd1);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_done",  32'(done),      32'd1);
        checkOutput("abort_err",   32'(err),       32'd1);
        checkOutput("abort_pdone", 32'(pass_done), 32'd0);

        applyStimulus(2'd0, 4'd2, 4'd1, 1'b0);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ctr_value == 4'd2 && !ctr_clear) begin found = 1; break; end
        end
        checkOutput("abort_term_reach", 32'(found), 32'd1);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_term_done", 32'(done), 32'd1);
        checkOutput("abort_term_err",  32'(err),  32'd1);
`else
        found = 0;
`endif

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            cmd_valid  = ($urandom % 4) == 0;
            cmd_mode   = 2'($urandom % 4);
            cmd_limit  = (($urandom % 8) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            cmd_passes = 4'($urandom_range(0, 3));
`ifdef COUNT_SEQ_ABORT_EN
            abort      = ($urandom % 50) == 0;
`endif
            if (($urandom % 400) == 0) begin
                clear_n = 1'b0;
                #1;
                clear_n = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        waitIdle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
